// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: counter encoding, table entry layout,
// and PC field extraction.
package bp_pkg;

  localparam int unsigned BP_XLEN     = 32;
  localparam int unsigned BP_IDX_BITS = 6;
  localparam int unsigned BP_TAG_W    = BP_XLEN - BP_IDX_BITS - 2;

  typedef enum logic [1:0] {
    CntSnt = 2'b00,
    CntWnt = 2'b01,
    CntWt  = 2'b10,
    CntSt  = 2'b11
  } bp_cnt_e;

  localparam bp_cnt_e CNT_RESET = CntWnt;
  localparam bp_cnt_e CNT_ALLOC = CntWt;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    bp_cnt_e             cnt;
  } bp_entry_t;

  // pc[1:0] never takes part in indexing or tagging.
  function automatic logic [BP_IDX_BITS-1:0] bp_idx(input logic [BP_XLEN-1:0] pc);
    return pc[BP_IDX_BITS+1:2];
  endfunction

  function automatic logic [BP_TAG_W-1:0] bp_tag(input logic [BP_XLEN-1:0] pc);
    return pc[BP_XLEN-1:BP_IDX_BITS+2];
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_counter
  import bp_pkg::*;
(
  input  bp_cnt_e cur,
  input  logic    taken,
  output bp_cnt_e nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != CntSt) nxt = bp_cnt_e'(cur + 2'd1);
    end else begin
      if (cur != CntSnt) nxt = bp_cnt_e'(cur - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter direction predictor with a tagged BTB, trained by resolved
// branches from execute, plus saturating branch/mispredict statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned XLEN     = BP_XLEN,
  parameter int unsigned IDX_BITS = BP_IDX_BITS,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  lk_pc,
  output logic             lk_taken,
  output logic [XLEN-1:0]  lk_target,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_pred_taken,
  input  logic [XLEN-1:0]  upd_pred_target,
  input  logic             flush,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int unsigned Entries = 2 ** IDX_BITS;

  bp_entry_t tbl_q [Entries];
  bp_entry_t tbl_d [Entries];

  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mp_count_q, mp_count_d;

  // Lookup reads registered contents only, so a same-cycle update is not bypassed.
  bp_entry_t lk_entry;
  logic      lk_hit;

  assign lk_entry  = tbl_q[bp_idx(lk_pc)];
  assign lk_hit    = lk_entry.valid && (lk_entry.tag == bp_tag(lk_pc));
  assign lk_taken  = lk_hit & lk_entry.cnt[1];
  assign lk_target = lk_taken ? lk_entry.target : lk_pc + XLEN'(4);

  logic [IDX_BITS-1:0] upd_idx;
  bp_entry_t           upd_entry;
  logic                upd_hit;
  bp_cnt_e             cnt_nxt;

  assign upd_idx   = bp_idx(upd_pc);
  assign upd_entry = tbl_q[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == bp_tag(upd_pc));

  bp_sat_counter u_sat_counter (
    .cur   (upd_entry.cnt),
    .taken (upd_taken),
    .nxt   (cnt_nxt)
  );

  assign mispredict = upd_valid & ((upd_pred_taken != upd_taken) |
                                   (upd_taken & (upd_pred_target != upd_target)));

  always_comb begin
    tbl_d = tbl_q;
    if (flush) begin
      // Flush drops any concurrent training; counters keep their history.
      for (int unsigned i = 0; i < Entries; i++) begin
        tbl_d[i].valid = 1'b0;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        tbl_d[upd_idx].cnt = cnt_nxt;
        if (upd_taken) tbl_d[upd_idx].target = upd_target;
      end else if (upd_taken) begin
        tbl_d[upd_idx] = '{valid: 1'b1, tag: bp_tag(upd_pc), target: upd_target,
                           cnt: CNT_ALLOC};
      end
    end
  end

  always_comb begin
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (upd_valid && (br_count_q != '1)) br_count_d = br_count_q + CNT_W'(1);
    if (mispredict && (mp_count_q != '1)) mp_count_d = mp_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_RESET};
      end
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      tbl_q      <= tbl_d;
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed literal checks plus randomized traffic compared each
// cycle against an array-based model of the predictor.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lk_pc;
  logic        lk_taken;
  logic [31:0] lk_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        flush;
  logic        mispredict;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .lk_pc           (lk_pc),
    .lk_taken        (lk_taken),
    .lk_target       (lk_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .flush           (flush),
    .mispredict      (mispredict),
    .br_count        (br_count),
    .mp_count        (mp_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: 64 entries, counter as an integer 0..3, tag = pc / 256.
  bit              m_valid [64];
  int unsigned     m_tag   [64];
  logic [31:0]     m_tgt   [64];
  int              m_cnt   [64];
  longint unsigned m_br, m_mp;

  function automatic int unsigned midx(input logic [31:0] pc);
    return (pc >> 2) % 64;
  endfunction

  function automatic int unsigned mtag(input logic [31:0] pc);
    return pc >> 8;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
  endfunction

  function automatic bit m_ptaken(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[midx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
    return m_ptaken(pc) ? m_tgt[midx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mispred();
    if (upd_valid !== 1'b1) return 1'b0;
    return (upd_pred_taken != upd_taken) || (upd_taken && (upd_pred_target != upd_target));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic m_step();
    int unsigned i;
    if (m_mispred() && m_mp != 64'hFFFF_FFFF) m_mp++;
    if (upd_valid === 1'b1 && m_br != 64'hFFFF_FFFF) m_br++;
    if (flush === 1'b1) begin
      for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
    end else if (upd_valid === 1'b1) begin
      i = midx(upd_pc);
      if (m_hit(upd_pc)) begin
        if (upd_taken) begin
          m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
          m_tgt[i] = upd_target;
        end else begin
          m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = mtag(upd_pc);
        m_tgt[i]   = upd_target;
        m_cnt[i]   = 2;
      end
    end
  endtask

  always @(posedge clk) if (rst_n === 1'b1) m_step();
  always @(negedge rst_n) m_reset();

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && rst_n === 1'b1) begin
      check("cmp_lk_taken", 32'(lk_taken), 32'(m_ptaken(lk_pc)));
      check("cmp_lk_target", lk_target, m_ptarget(lk_pc));
      check("cmp_mispredict", 32'(mispredict), 32'(m_mispred()));
      check("cmp_br_count", br_count, 32'(m_br));
      check("cmp_mp_count", mp_count, 32'(m_mp));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] t;
    logic [5:0]  ix;
    logic [1:0]  lo;
    case ($urandom_range(0, 3))
      0:       t = 32'h0;
      1:       t = 32'h1;
      2:       t = 32'h2;
      default: t = 32'h00FF_FFFF;
    endcase
    ix = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
    lo = 2'($urandom_range(0, 3));
    return {t[23:0], ix, lo};
  endfunction

  task automatic rand_cycle(input bit allow_flush);
    lk_pc = rand_pc();
    flush = allow_flush && ($urandom_range(0, 63) == 0);
    if ($urandom_range(0, 1) == 1) begin
      upd_valid  = 1'b1;
      upd_pc     = rand_pc();
      upd_taken  = ($urandom_range(0, 2) != 0);
      upd_target = 32'h1000 + 32'($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 3) != 0) begin
        upd_pred_taken  = m_ptaken(upd_pc);
        upd_pred_target = m_ptarget(upd_pc);
      end else begin
        upd_pred_taken  = 1'($urandom_range(0, 1));
        upd_pred_target = 32'h1000 + 32'($urandom_range(0, 3) << 2);
      end
    end else begin
      upd_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        upd_pc          = 'x;
        upd_taken       = 1'bx;
        upd_target      = 'x;
        upd_pred_taken  = 1'bx;
        upd_pred_target = 'x;
      end else begin
        upd_pc          = rand_pc();
        upd_taken       = 1'($urandom_range(0, 1));
        upd_target      = $urandom;
        upd_pred_taken  = 1'($urandom_range(0, 1));
        upd_pred_target = $urandom;
      end
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    lk_pc = 32'h0;
    flush = 1'b0;
    drive_upd(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    upd_valid = 1'b0;
    m_reset();
    #22;
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();

    // Reset state and wrap of pc+4.
    lk_pc = 32'h100;
    #1;
    check("rst_lk_taken", 32'(lk_taken), 32'h0);
    check("rst_lk_target", lk_target, 32'h104);
    check("rst_br_count", br_count, 32'h0);
    check("rst_mp_count", mp_count, 32'h0);
    lk_pc = 32'hFFFF_FFFC;
    #1;
    check("wrap_lk_target", lk_target, 32'h0);
    lk_pc = 32'h100;

    // Allocate and predict.
    drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    check("alloc_mispredict", 32'(mispredict), 32'h1);
    tick();
    upd_valid = 1'b0;
    #1;
    check("alloc_mp_count", mp_count, 32'h1);
    check("alloc_br_count", br_count, 32'h1);
    check("alloc_lk_taken", 32'(lk_taken), 32'h1);
    check("alloc_lk_target", lk_target, 32'h80);

    // Saturation: ST then two not-taken steps down to WNT.
    repeat (5) begin
      drive_upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      tick();
    end
    drive_upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    check("sat_nt_mispredict", 32'(mispredict), 32'h1);
    tick();
    upd_valid = 1'b0;
    #1;
    check("sat_wt_lk_taken", 32'(lk_taken), 32'h1);
    check("sat_wt_lk_target", lk_target, 32'h80);
    drive_upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    tick();
    upd_valid = 1'b0;
    #1;
    check("sat_wnt_lk_taken", 32'(lk_taken), 32'h0);
    check("sat_wnt_lk_target", lk_target, 32'h104);
    drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    tick();
    upd_valid = 1'b0;
    #1;
    check("retrain_lk_taken", 32'(lk_taken), 32'h1);

    // Alias at the same index with a different tag.
    lk_pc = 32'h200;
    #1;
    check("alias_lk_taken", 32'(lk_taken), 32'h0);
    check("alias_lk_target", lk_target, 32'h204);
    drive_upd(32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
    tick();
    upd_valid = 1'b0;
    lk_pc = 32'h100;
    #1;
    check("evict_old_lk_taken", 32'(lk_taken), 32'h0);
    check("evict_old_lk_target", lk_target, 32'h104);
    lk_pc = 32'h200;
    #1;
    check("evict_new_lk_target", lk_target, 32'h300);

    // Same-cycle lookup and update return the old prediction.
    drive_upd(32'h200, 1'b0, 32'h300, 1'b1, 32'h300);
    #1;
    check("rdw_old_lk_taken", 32'(lk_taken), 32'h1);
    tick();
    upd_valid = 1'b0;
    #1;
    check("rdw_new_lk_taken", 32'(lk_taken), 32'h0);

    // Flush beats a simultaneous allocate; statistics still count it.
    drive_upd(32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
    tick();
    flush = 1'b1;
    drive_upd(32'h140, 1'b1, 32'h500, 1'b0, 32'h0);
    tick();
    flush     = 1'b0;
    upd_valid = 1'b0;
    #1;
    check("flush_br_count", br_count, 32'd13);
    check("flush_mp_count", mp_count, 32'd8);
    check("flush_old_lk_taken", 32'(lk_taken), 32'h0);
    lk_pc = 32'h140;
    #1;
    check("flush_new_lk_taken", 32'(lk_taken), 32'h0);
    check("flush_new_lk_target", lk_target, 32'h144);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) rand_cycle(1'b1);

    // Async reset between edges with an update in flight.
    flush = 1'b0;
    drive_upd(32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
    tick();
    lk_pc = 32'h200;
    drive_upd(32'h200, 1'b1, 32'h400, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_lk_taken", 32'(lk_taken), 32'h0);
    check("areset_lk_target", lk_target, 32'h204);
    check("areset_br_count", br_count, 32'h0);
    check("areset_mp_count", mp_count, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    upd_valid = 1'b0;
    rst_n     = 1'b1;
    #1;
    check("post_reset_lk_taken", 32'(lk_taken), 32'h0);
    check("post_reset_br_count", br_count, 32'h0);

    for (int n = 0; n < 500; n++) rand_cycle(1'b1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
